// File: rtl/mem_access_stage_if.sv
// Data-memory valid/ready port between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [BE_W-1:0]   dmem_be;
    logic              dmem_ready;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: issues load/store transactions on the data-memory port, aligns and
// extends load data, and holds the MEM/WB pipeline register.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_to_reg,
    input  logic        ex_mem_write,
    input  logic        ex_mem_read,
    input  logic [2:0]  ex_funct3,
    output logic        mem_stall,
    mem_access_stage_if.master dmem,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        access_fault,
    output logic        bus_err
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              req, req_nxt, we, we_nxt;
    logic [31:0]       addr, addr_nxt, wdata, wdata_nxt;
    logic [3:0]        be, be_nxt;
    logic [1:0]        lo, lo_nxt;
    logic [2:0]        f3, f3_nxt;
    logic [4:0]        rd, rd_nxt;
    logic              rw, rw_nxt, m2r, m2r_nxt;
    logic [31:0]       wb_data_nxt;
    logic [4:0]        wb_rd_nxt;
    logic              wb_reg_write_nxt, fault_nxt, err_nxt;

    logic              is_load, mem_op, funct_ok, misaligned, legal_op, fault_op, timeout_hit;
    logic [31:0]       st_wdata, ld_data;
    logic [3:0]        st_be;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;

    // Access classification of the instruction sitting in EX/MEM
    always_comb begin
        is_load    = ex_mem_read & ~ex_mem_write;
        mem_op     = ex_mem_read ^ ex_mem_write;
        funct_ok   = 1'b0;
        misaligned = 1'b0;
        case (ex_funct3)
            3'b000:         funct_ok = 1'b1;
            3'b001:         begin funct_ok = 1'b1; misaligned = ex_alu_out[0]; end
            3'b010:         begin funct_ok = 1'b1; misaligned = |ex_alu_out[1:0]; end
            3'b100:         funct_ok = is_load;
            3'b101:         begin funct_ok = is_load; misaligned = ex_alu_out[0]; end
            default:        funct_ok = 1'b0;
        endcase
        legal_op    = mem_op & funct_ok & ~misaligned;
        fault_op    = (ex_mem_read & ex_mem_write) | (mem_op & ~legal_op);
        timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    end

    // Store lane replication and byte enables
    always_comb begin
        st_wdata = ex_store_data;
        st_be    = 4'b1111;
        case (ex_funct3[1:0])
            2'b00:   begin st_wdata = {4{ex_store_data[7:0]}};  st_be = 4'b0001 << ex_alu_out[1:0]; end
            2'b01:   begin st_wdata = {2{ex_store_data[15:0]}}; st_be = ex_alu_out[1] ? 4'b1100 : 4'b0011; end
            default: begin st_wdata = ex_store_data;            st_be = 4'b1111; end
        endcase
    end

    // Load lane extraction and extension using the captured access
    always_comb begin
        lane_b = 8'(dmem.dmem_rdata >> {lo, 3'b000});
        lane_h = lo[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (f3)
            3'b000:  ld_data = {{24{lane_b[7]}}, lane_b};
            3'b001:  ld_data = {{16{lane_h[15]}}, lane_h};
            3'b100:  ld_data = {24'b0, lane_b};
            3'b101:  ld_data = {16'b0, lane_h};
            default: ld_data = dmem.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state, bus fields and MEM/WB contents
    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        req_nxt          = req;
        we_nxt           = we;
        addr_nxt         = addr;
        wdata_nxt        = wdata;
        be_nxt           = be;
        lo_nxt           = lo;
        f3_nxt           = f3;
        rd_nxt           = rd;
        rw_nxt           = rw;
        m2r_nxt          = m2r;
        wb_data_nxt      = wb_data;
        wb_rd_nxt        = wb_rd;
        wb_reg_write_nxt = wb_reg_write;
        fault_nxt        = 1'b0;
        err_nxt          = 1'b0;
        mem_stall        = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (legal_op) begin
                    state_nxt        = BUSY;
                    req_nxt          = 1'b1;
                    we_nxt           = ~is_load;
                    addr_nxt         = {ex_alu_out[31:2], 2'b00};
                    wdata_nxt        = is_load ? 32'h0 : st_wdata;
                    be_nxt           = is_load ? 4'b0000 : st_be;
                    lo_nxt           = ex_alu_out[1:0];
                    f3_nxt           = ex_funct3;
                    rd_nxt           = ex_rd;
                    rw_nxt           = ex_reg_write;
                    m2r_nxt          = ex_mem_to_reg;
                    wb_data_nxt      = '0;
                    wb_rd_nxt        = '0;
                    wb_reg_write_nxt = 1'b0;
                    mem_stall        = 1'b1;
                end else if (fault_op) begin
                    fault_nxt        = 1'b1;
                    wb_data_nxt      = '0;
                    wb_rd_nxt        = '0;
                    wb_reg_write_nxt = 1'b0;
                end else begin
                    wb_data_nxt      = ex_alu_out;
                    wb_rd_nxt        = ex_rd;
                    wb_reg_write_nxt = ex_reg_write;
                end
            end
            BUSY: begin
                if (dmem.dmem_ready) begin
                    state_nxt        = IDLE;
                    req_nxt          = 1'b0;
                    cnt_nxt          = '0;
                    wb_data_nxt      = m2r ? ld_data : {addr[31:2], lo};
                    wb_rd_nxt        = rd;
                    wb_reg_write_nxt = rw;
                end else if (timeout_hit) begin
                    state_nxt        = IDLE;
                    req_nxt          = 1'b0;
                    cnt_nxt          = '0;
                    err_nxt          = 1'b1;
                    wb_data_nxt      = '0;
                    wb_rd_nxt        = '0;
                    wb_reg_write_nxt = 1'b0;
                end else begin
                    cnt_nxt          = cnt + CNT_W'(1);
                    mem_stall        = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (!rst) mem_stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt          <= '0;
            req          <= 1'b0;
            we           <= 1'b0;
            addr         <= '0;
            wdata        <= '0;
            be           <= '0;
            lo           <= '0;
            f3           <= '0;
            rd           <= '0;
            rw           <= 1'b0;
            m2r          <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            access_fault <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            req          <= req_nxt;
            we           <= we_nxt;
            addr         <= addr_nxt;
            wdata        <= wdata_nxt;
            be           <= be_nxt;
            lo           <= lo_nxt;
            f3           <= f3_nxt;
            rd           <= rd_nxt;
            rw           <= rw_nxt;
            m2r          <= m2r_nxt;
            wb_data      <= wb_data_nxt;
            wb_rd        <= wb_rd_nxt;
            wb_reg_write <= wb_reg_write_nxt;
            access_fault <= fault_nxt;
            bus_err      <= err_nxt;
        end
    end

    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = we;
    assign dmem.dmem_addr  = addr;
    assign dmem.dmem_wdata = wdata;
    assign dmem.dmem_be    = be;
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage of the five-stage RISC-V pipeline. It consumes the EX/MEM pipeline register outputs, runs load/store transactions on a valid/ready data-memory port, and aligns and extends load data. It also contains the MEM/WB pipeline register. It stalls the upstream pipeline while a transaction is outstanding and flags misaligned accesses, illegal accesses and bus timeouts.

## Interface
- TIMEOUT, 255: max cycles in BUSY without dmem_ready before abort (1..255, 8-bit counter)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- ex_alu_out  in  32  effective address / pass-through result
- ex_store_data  in  32  forwarded rs2 value
- ex_rd  in  5  destination register
- ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_mem_read  in  1 each  control from EX/MEM
- ex_funct3  in  3  access size/sign
- mem_stall  out  1  freeze request; upstream EX/MEM en = ~mem_stall
- dmem_req  out  1  transaction valid (registered)
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  transaction complete; rdata valid same cycle
- dmem_rdata  in  32  load word
- wb_data  out  32  MEM/WB result (load data if mem_to_reg, else ALU output)
- wb_rd  out  5  MEM/WB destination
- wb_reg_write  out  1  MEM/WB write enable
- access_fault  out  1  one-cycle pulse: misaligned or illegal access
- bus_err  out  1  one-cycle pulse: timeout abort

## Operation
- Memory op: ex_mem_read XOR ex_mem_write. Both set, or funct3 not in {LB 000, LH 001, LW 010, LBU 100, LHU 101} for loads or {SB 000, SH 001, SW 010} for stores, is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
- FSM states IDLE, BUSY.
  - IDLE, no memory op: MEM/WB loads ex_alu_out, ex_rd, ex_reg_write every cycle.
  - IDLE, legal aligned op: capture addr, wdata, be, we, rd, funct3 and control; dmem_req←1; go to BUSY; load a bubble (wb_reg_write=0) into MEM/WB.
  - IDLE, illegal or misaligned op: no request, access_fault=1 next cycle, bubble into MEM/WB, no stall.
  - BUSY: dmem_req held with all bus fields stable. On dmem_ready: dmem_req←0; MEM/WB loads the extended load data (or nothing for a store, wb_reg_write = captured reg_write); go to IDLE; counter cleared.
  - BUSY with counter = TIMEOUT−1 and no ready: dmem_req←0, bus_err=1, bubble into MEM/WB, go to IDLE.
- mem_stall (combinational) = rst & ((IDLE & legal aligned op) | (BUSY & ~dmem_ready & not timing out)).
- Store lanes:
  - SB: wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{d[15:0]}}, be=addr[1]?1100:0011.
  - SW: wdata=d, be=1111.
- Load extract: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend.

## Timing
- Reset (rst=0 at an edge): state IDLE, counter 0; all registered outputs 0 (wb_data, wb_rd, wb_reg_write, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, access_fault, bus_err). mem_stall=0 while rst=0. Reset mid-BUSY drops dmem_req at that edge; the transaction is abandoned.
- Non-memory op: 1 cycle EX/MEM→MEM/WB, no stall.
- Memory op: request visible 1 cycle after entry. With ready in the first BUSY cycle, MEM/WB is valid 2 cycles after entry. Each extra wait cycle adds 1.
- The upstream instruction is held during the entire stall. The stall deasserts in the dmem_ready cycle so the next instruction enters on that same edge.
- Timeout: bus_err is asserted exactly TIMEOUT cycles after dmem_req rises.
- A dmem_ready in IDLE is ignored.

## Test plan
- ALU pass-through: ex_alu_out=0x1234, rd=5, reg_write=1, no mem → next cycle wb_data=0x1234, wb_rd=5, wb_reg_write=1, mem_stall never 1.
- LB at 0x103, dmem_rdata=0x80FF_0000, ready after 3 wait cycles → dmem_addr=0x100, be=0000, we=0; wb_data=0xFFFF_FF80; mem_stall high 4 cycles.
- SH data 0xABCD at 0x202, ready immediately → dmem_wdata=0xABCD_ABCD, be=1100, we=1; wb_reg_write=0.
- LW at 0x101 → access_fault pulse, dmem_req stays 0, no stall, wb_reg_write=0.
- TIMEOUT=4, LW, dmem_ready held 0 → dmem_req high 4 cycles, then bus_err pulse, stall released, bubble into MEM/WB.
- rst=0 during BUSY → dmem_req 0 next cycle, all outputs 0; a later LBU at 0x2 with rdata 0x00AA_0000 returns 0x0000_00AA.
